// File: rtl/uart_transceiver_if.sv
// uart_transceiver_if: command strobes, data bus and status between the control unit and the UART.
interface uart_transceiver_if;
   logic        uart_receive;
   logic        uart_in_and_send;
   logic        uart_out;
   logic [15:0] bus_in;
   logic [15:0] bus_out;
   logic        uart_done;
   logic        busy;
   logic        frame_err;
   modport master (
      output uart_receive, uart_in_and_send, uart_out, bus_in,
      input  bus_out, uart_done, busy, frame_err
   );
   modport slave (
      input  uart_receive, uart_in_and_send, uart_out, bus_in,
      output bus_out, uart_done, busy, frame_err
   );
endinterface

// File: rtl/uart_transceiver.sv
// uart_transceiver: 8N1 UART, one byte per command strobe, one-cycle uart_done pulse on completion.
// Defining UART_RX_TIMEOUT_EN aborts a receive when no start bit arrives within TIMEOUT_BITS bit periods.
module uart_transceiver #(
   parameter int CLKS_PER_BIT = 104,
   parameter int TIMEOUT_BITS = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   uart_transceiver_if.slave bus,
   input  logic              rx_i,
   output logic              tx_o
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_BITS + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_BITS - 1);
   logic [TW-1:0] tmo_q;
`else
   localparam int unused_timeout_bits = TIMEOUT_BITS;
`endif
   typedef enum logic [3:0] {
      IDLE, RX_WAIT, RX_START, RX_DATA, RX_STOP, TX_START, TX_DATA, TX_STOP, DONE
   } state_t;
   state_t        state_q;
   logic [CW-1:0] clk_cnt_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    tx_shift_q, rx_shift_q, rx_data_q;
   logic [1:0]    rx_sync_q;
   logic          tx_q, done_q, busy_q, frame_err_q;
   logic          rx_s, bit_end, unused_bus_hi;
   assign rx_s          = rx_sync_q[1];
   assign bit_end       = clk_cnt_q == LAST;
   assign unused_bus_hi = ^bus.bus_in[15:8];
   assign tx_o          = tx_q;
   assign bus.uart_done = done_q;
   assign bus.busy      = busy_q;
   assign bus.frame_err = frame_err_q;
   assign bus.bus_out   = bus.uart_out ? {8'h00, rx_data_q} : 16'h0000;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rx_sync_q <= 2'b11;
      else        rx_sync_q <= {rx_sync_q[0], rx_i};
   // clk_cnt free-runs within a bit period; states that need a fresh period zero it on entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         tx_q        <= 1'b1;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         done_q    <= 1'b0;
         clk_cnt_q <= bit_end ? '0 : clk_cnt_q + CW'(1);
         unique case (state_q)
            IDLE: begin
               clk_cnt_q <= '0;
               bit_idx_q <= '0;
`ifdef UART_RX_TIMEOUT_EN
               tmo_q     <= '0;
`endif
               if (bus.uart_receive) begin
                  state_q     <= RX_WAIT;
                  busy_q      <= 1'b1;
                  frame_err_q <= 1'b0;
               end else if (bus.uart_in_and_send) begin
                  state_q    <= TX_START;
                  busy_q     <= 1'b1;
                  tx_shift_q <= bus.bus_in[7:0];
                  tx_q       <= 1'b0;
               end
            end
            RX_WAIT: begin
`ifdef UART_RX_TIMEOUT_EN
               if (bit_end) tmo_q <= tmo_q + TW'(1);
               if (bit_end && tmo_q == TMO_LAST) begin
                  rx_data_q   <= 8'h00;
                  frame_err_q <= 1'b1;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end else
`endif
               if (!rx_s) begin
                  state_q   <= RX_START;
                  clk_cnt_q <= '0;
               end
            end
            RX_START:
               if (clk_cnt_q == HALF) begin
                  clk_cnt_q <= '0;
                  state_q   <= rx_s ? RX_WAIT : RX_DATA;
               end
            RX_DATA:
               if (bit_end) begin
                  rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                  bit_idx_q  <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) state_q <= RX_STOP;
               end
            RX_STOP:
               if (bit_end) begin
                  frame_err_q <= !rx_s;
                  rx_data_q   <= rx_shift_q;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end
            TX_START:
               if (bit_end) begin
                  tx_q    <= tx_shift_q[0];
                  state_q <= TX_DATA;
               end
            TX_DATA:
               if (bit_end) begin
                  tx_shift_q <= tx_shift_q >> 1;
                  bit_idx_q  <= bit_idx_q + 3'd1;
                  tx_q       <= bit_idx_q == 3'd7 ? 1'b1 : tx_shift_q[1];
                  state_q    <= bit_idx_q == 3'd7 ? TX_STOP : TX_DATA;
               end
            TX_STOP:
               if (bit_end) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
